// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// A miss write-backs a dirty victim (WB), refills the line (ALLOC), then the access hits in IDLE.
module dcache_direct_mapped #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 30 - INDEX_W - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [1:0]         addr_off;
    logic [6:0]         word_lsb;
    logic               req;
    logic               hit;
    logic               line_fill;
    logic               word_we;

    assign addr_tag = proc_addr[INDEX_W+2 +: TAG_W];
    assign addr_idx = proc_addr[2 +: INDEX_W];
    assign addr_off = proc_addr[1:0];
    assign word_lsb = {addr_off, 5'd0};

    assign req        = proc_read || proc_write;
    assign hit        = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign proc_stall = req && !(state_q == IDLE && hit);
    assign proc_rdata = data_q[addr_idx][word_lsb +: 32];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        line_fill = 1'b0;
        word_we   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = {addr_tag, addr_idx};
        mem_wdata = data_q[addr_idx];
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // a simultaneous read+write request is serviced as a store
                        if (proc_write) begin
                            word_we           = 1'b1;
                            dirty_d[addr_idx] = 1'b1;
                        end
                    end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                        state_d = WB;
                    end else begin
                        state_d = ALLOC;
                    end
                end
            end
            WB: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[addr_idx], addr_idx};
                if (mem_ready) begin
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    line_fill         = 1'b1;
                    valid_d[addr_idx] = 1'b1;
                    dirty_d[addr_idx] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Line storage carries no reset; validity alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (line_fill) begin
            data_q[addr_idx] <= mem_rdata;
            tag_q[addr_idx]  <= addr_tag;
        end else if (word_we) begin
            data_q[addr_idx][word_lsb +: 32] <= proc_wdata;
        end
    end

endmodule
